counter_ud_mod: RTL and testbench
=================================

Name: counter_ud_mod

Overview:
Parametrised up/down counter. Adds a runtime modulus (`max_val`), a programmable step, wrap or saturate mode, and count enable. Flags are registered, one cycle wide, and separated into rollover (up), underflow (down) and saturation, plus boundary status outputs. Used as the general-purpose event/timer counter in datapath blocks, replacing fixed 4-bit up/down counters.

Parameters:
- WIDTH, 8, counter and limit width in bits (≥2).
- STEP_W, 4, step input width in bits (1..WIDTH).
- RST_VAL, 0, count value after reset (must be ≤ 2**WIDTH-1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable; one step per enabled cycle.
- ud  in  1  direction: 1 = up, 0 = down.
- step  in  STEP_W  increment/decrement amount.
- max_val  in  WIDTH  terminal value; count range is 0..max_val.
- sat_mode  in  1  1 = saturate at bounds, 0 = wrap modulo max_val+1.
- load_en  in  1  synchronous load strobe.
- load  in  WIDTH  load value.
- count  out  WIDTH  registered count.
- rollover  out  1  registered one-cycle pulse: upward wrap occurred.
- underflow  out  1  registered one-cycle pulse: downward wrap occurred.
- sat  out  1  registered one-cycle pulse: a step was clamped in sat_mode.
- at_max  out  1  combinational: count == max_val.
- at_zero  out  1  combinational: count == 0.

Behaviour:
- Reset (async, any time, including mid-operation):
  - count = RST_VAL; rollover, underflow and sat = 0 immediately.
  - Counting resumes on the first posedge after rst deasserts.
- Priority per posedge: rst > load_en > en > hold.
- Load:
  - count ← min(load, max_val).
  - All flags 0 that cycle.
  - en is ignored when load_en = 1.
- Enabled step:
  - Effective step s = min(step, max_val+1). Compute in WIDTH+1 bits; no intermediate overflow is permitted.
  - s = 0: count holds, flags 0.
- Out-of-range recovery: if count > max_val (max_val lowered at runtime) and en = 1, count ← max_val, flags 0. Direction and step are ignored that cycle.
- Up, wrap mode:
  - If count + s ≤ max_val: count + s.
  - Else: count + s − (max_val+1), and rollover = 1.
- Down, wrap mode:
  - If count ≥ s: count − s.
  - Else: count + (max_val+1) − s, and underflow = 1.
- Up, sat mode: if count + s > max_val, count ← max_val and sat = 1. If already at max_val, sat pulses again on every enabled up cycle.
- Down, sat mode: if count < s, count ← 0 and sat = 1. rollover and underflow are never set in sat mode.
- Flags:
  - Registered alongside count: visible in the same cycle count shows the wrapped or clamped value.
  - Cleared on the next posedge unless the event repeats.
- Latency: 1 clock from sampled inputs to count and flags.
- Degenerate case max_val = 0:
  - Count stays 0.
  - Wrap mode with s = 1: rollover pulses on every enabled up cycle; underflow pulses on every enabled down cycle.
- Changing ud, step, max_val or sat_mode between cycles is legal and takes effect on the next edge.

Decomposition:
- Package counter_ud_pkg:
  - mode enum {MODE_WRAP, MODE_SAT}.
  - Direction constants DIR_UP = 1'b1, DIR_DOWN = 1'b0.
  - Flag struct {rollover, underflow, sat}.
- Sub-module counter_ud_next: purely combinational next-count and flag calculator (inputs count, s, max_val, ud, mode). The top holds the registers, priority logic and clamping. This allows the arithmetic to be unit-tested in isolation.

Test Plan (WIDTH = 8, STEP_W = 4):
1. rst = 1 asserted mid-cycle while count = 7 and en = 1 → count = 0 and all flags 0 before the next edge. After deassert, the first enabled up step (step = 1) gives 1.
2. load = 5, max_val = 9, wrap, up, step = 1 for 6 cycles → 6, 7, 8, 9, 0 (rollover = 1 on this cycle only), then 1.
3. load = 1, max_val = 9, wrap, down, step = 3 → 8 (underflow = 1), then 5 (underflow = 0), then 2.
4. Sat mode, max_val = 10, load = 8, up, step = 4 → 10 with sat = 1; stays 10 with sat = 1 each cycle. Switch to down, step = 15 → 0 with sat = 1; at_zero = 1.
5. Load handling:
   - load = 200 with max_val = 100 → count = 100, at_max = 1.
   - load_en = 1 with en = 1 and load = 3 → count = 3, no flags.
6. Runtime limit and zero step:
   - count = 7, max_val changed to 3, en = 1, up → count = 3 with no flags.
   - Then step = 0 for 4 cycles → count holds 3, all flags 0.

Source files
------------

// File: rtl/counter_ud_pkg.sv
// Shared types for the up/down modulus counter: counting mode, direction
// encodings and the per-cycle event flag bundle.
package counter_ud_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef struct packed {
        logic rollover;
        logic underflow;
        logic sat;
    } flags_t;

endpackage

// File: rtl/counter_ud_next.sv
// Combinational next-count and event-flag calculator for an in-range count.
// The caller guarantees i_count <= i_max_val and i_step <= i_max_val + 1.
module counter_ud_next
    import counter_ud_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic [WIDTH:0]   i_step,
    input  logic [WIDTH-1:0] i_max_val,
    input  logic             i_ud,
    input  mode_e            i_mode,
    output logic [WIDTH-1:0] o_count,
    output flags_t           o_flags
);

    logic [WIDTH:0]   w_cnt_x;
    logic [WIDTH:0]   w_max_x;
    logic [WIDTH:0]   w_lim;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_wrap_up;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_wrap_dn;

    // All intermediates fit in WIDTH+1 bits because count < lim and step <= lim.
    assign w_cnt_x   = {1'b0, i_count};
    assign w_max_x   = {1'b0, i_max_val};
    assign w_lim     = w_max_x + 1'b1;
    assign w_sum     = w_cnt_x + i_step;
    assign w_wrap_up = WIDTH'(w_sum - w_lim);
    assign w_diff    = WIDTH'(w_cnt_x - i_step);
    assign w_wrap_dn = WIDTH'(w_cnt_x + w_lim - i_step);

    always_comb begin
        o_count = i_count;
        o_flags = '0;
        if (i_ud == DIR_UP) begin
            if (w_sum > w_max_x) begin
                if (i_mode == MODE_SAT) begin
                    o_count     = i_max_val;
                    o_flags.sat = 1'b1;
                end else begin
                    o_count          = w_wrap_up;
                    o_flags.rollover = 1'b1;
                end
            end else begin
                o_count = w_sum[WIDTH-1:0];
            end
        end else begin
            if (w_cnt_x >= i_step) begin
                o_count = w_diff;
            end else if (i_mode == MODE_SAT) begin
                o_count     = '0;
                o_flags.sat = 1'b1;
            end else begin
                o_count           = w_wrap_dn;
                o_flags.underflow = 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_ud_mod.sv
// Up/down counter with runtime modulus, programmable step, wrap/saturate mode
// and registered one-cycle event flags.
module counter_ud_mod
    import counter_ud_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               STEP_W  = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_ud,
    input  logic [STEP_W-1:0] i_step,
    input  logic [WIDTH-1:0]  i_max_val,
    input  logic              i_sat_mode,
    input  logic              i_load_en,
    input  logic [WIDTH-1:0]  i_load,
    output logic [WIDTH-1:0]  o_count,
    output logic              o_rollover,
    output logic              o_underflow,
    output logic              o_sat,
    output logic              o_at_max,
    output logic              o_at_zero
);

    logic [WIDTH-1:0] r_count;
    flags_t           r_flags;

    logic [WIDTH:0]   w_step_x;
    logic [WIDTH:0]   w_lim;
    logic [WIDTH:0]   w_s;
    logic [WIDTH-1:0] w_load_clip;
    logic [WIDTH-1:0] w_next;
    flags_t           w_next_flags;

    assign w_step_x    = {{(WIDTH + 1 - STEP_W){1'b0}}, i_step};
    assign w_lim       = {1'b0, i_max_val} + 1'b1;
    assign w_s         = (w_step_x > w_lim) ? w_lim : w_step_x;
    assign w_load_clip = (i_load > i_max_val) ? i_max_val : i_load;

    counter_ud_next #(
        .WIDTH(WIDTH)
    ) u_next (
        .i_count  (r_count),
        .i_step   (w_s),
        .i_max_val(i_max_val),
        .i_ud     (i_ud),
        .i_mode   (mode_e'(i_sat_mode)),
        .o_count  (w_next),
        .o_flags  (w_next_flags)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= RST_VAL;
            r_flags <= '0;
        end else begin
            r_flags <= '0;
            if (i_load_en) begin
                r_count <= w_load_clip;
            end else if (i_en) begin
                // A limit lowered below the count snaps back to the limit first.
                if (r_count > i_max_val) begin
                    r_count <= i_max_val;
                end else begin
                    r_count <= w_next;
                    r_flags <= w_next_flags;
                end
            end
        end
    end

    assign o_count     = r_count;
    assign o_rollover  = r_flags.rollover;
    assign o_underflow = r_flags.underflow;
    assign o_sat       = r_flags.sat;
    assign o_at_max    = (r_count == i_max_val);
    assign o_at_zero   = (r_count == '0);

endmodule

// File: tb/tb_counter_ud_mod.sv
// Self-checking bench for counter_ud_mod: directed vector table, async-reset
// sequences and randomized traffic against an arithmetic reference model.
module tb_counter_ud_mod;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       ud = 1'b1;
    logic [3:0] step = 4'd1;
    logic [7:0] max_val = 8'd255;
    logic       sat_mode = 1'b0;
    logic       load_en = 1'b0;
    logic [7:0] load = 8'd0;
    logic [7:0] count;
    logic       rollover, underflow, sat, at_max, at_zero;

    int checks = 0;
    int errors = 0;

    counter_ud_mod #(.WIDTH(8), .STEP_W(4), .RST_VAL(8'd0)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_ud       (ud),
        .i_step     (step),
        .i_max_val  (max_val),
        .i_sat_mode (sat_mode),
        .i_load_en  (load_en),
        .i_load     (load),
        .o_count    (count),
        .o_rollover (rollover),
        .o_underflow(underflow),
        .o_sat      (sat),
        .o_at_max   (at_max),
        .o_at_zero  (at_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ld_en;
        logic [7:0] ld;
        logic       en;
        logic       ud;
        logic [3:0] step;
        logic [7:0] mx;
        logic       sat;
        int         ec;
        logic       er;
        logic       eu;
        logic       es;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic ld_en_i, int ld_i, logic en_i, logic ud_i, int step_i,
                                int mx_i, logic sat_i, int ec_i, logic er_i, logic eu_i, logic es_i);
        vec_t v;
        v.ld_en = ld_en_i; v.ld = 8'(ld_i); v.en = en_i; v.ud = ud_i; v.step = 4'(step_i);
        v.mx = 8'(mx_i); v.sat = sat_i; v.ec = ec_i; v.er = er_i; v.eu = eu_i; v.es = es_i;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int ec, input logic er, input logic eu, input logic es);
        chk({tag, ".count"}, 32'(count), 32'(ec));
        chk({tag, ".rollover"}, 32'(rollover), 32'(er));
        chk({tag, ".underflow"}, 32'(underflow), 32'(eu));
        chk({tag, ".sat"}, 32'(sat), 32'(es));
        chk({tag, ".at_max"}, 32'(at_max), 32'(ec == int'(max_val)));
        chk({tag, ".at_zero"}, 32'(at_zero), 32'(ec == 0));
    endtask

    // Reference model state.
    int   m_count;
    logic m_r, m_u, m_s;

    task automatic model_step();
        int mx, s, t;
        mx = int'(max_val);
        m_r = 1'b0; m_u = 1'b0; m_s = 1'b0;
        if (load_en) begin
            m_count = (int'(load) < mx) ? int'(load) : mx;
        end else if (en) begin
            if (m_count > mx) begin
                m_count = mx;
            end else begin
                s = (int'(step) < mx + 1) ? int'(step) : mx + 1;
                if (ud) begin
                    t = m_count + s;
                    if (t <= mx) m_count = t;
                    else if (sat_mode) begin m_count = mx; m_s = 1'b1; end
                    else begin m_count = t - (mx + 1); m_r = 1'b1; end
                end else begin
                    if (m_count >= s) m_count = m_count - s;
                    else if (sat_mode) begin m_count = 0; m_s = 1'b1; end
                    else begin m_count = m_count + (mx + 1) - s; m_u = 1'b1; end
                end
            end
        end
    endtask

    initial begin
        // Reset state
        #2;
        chk_all("reset", 0, 0, 0, 0);
        #10;
        rst = 1'b0;

        // Async reset mid-cycle while counting from 7
        max_val = 8'd9; load_en = 1'b1; load = 8'd6; tick();
        load_en = 1'b0; en = 1'b1; ud = 1'b1; step = 4'd1; tick();
        chk_all("pre_rst", 7, 0, 0, 0);
        #2 rst = 1'b1;
        #1 chk_all("async_rst", 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        chk_all("post_rst", 1, 0, 0, 0);

        // Async reset clears a live rollover pulse immediately
        load_en = 1'b1; load = 8'd9; tick();
        load_en = 1'b0; tick();
        chk_all("roll_pre_rst", 0, 1, 0, 0);
        #2 rst = 1'b1;
        #1 chk("rst_clears_roll", 32'(rollover), 32'd0);
        rst = 1'b0;
        en = 1'b0;
        tick();

        //          ld_en ld en ud step mx sat   cnt r u s
        vecs.push_back(mk(1, 5,   0, 1, 1,  9,  0,  5, 0, 0, 0));
        vecs.push_back(mk(0, 0,   1, 1, 1,  9,  0,  6, 0, 0, 0));
        vecs.push_back(mk(0, 0,   1, 1, 1,  9,  0,  7, 0, 0, 0));
        vecs.push_back(mk(0, 0,   1, 1, 1,  9,  0,  8, 0, 0, 0));
        vecs.push_back(mk(0, 0,   1, 1, 1,  9,  0,  9, 0, 0, 0));
        vecs.push_back(mk(0, 0,   1, 1, 1,  9,  0,  0, 1, 0, 0));
        vecs.push_back(mk(0, 0,   1, 1, 1,  9,  0,  1, 0, 0, 0));
        vecs.push_back(mk(1, 1,   0, 0, 3,  9,  0,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0,   1, 0, 3,  9,  0,  8, 0, 1, 0));
        vecs.push_back(mk(0, 0,   1, 0, 3,  9,  0,  5, 0, 0, 0));
        vecs.push_back(mk(0, 0,   1, 0, 3,  9,  0,  2, 0, 0, 0));
        vecs.push_back(mk(1, 8,   0, 1, 4,  10, 1,  8, 0, 0, 0));
        vecs.push_back(mk(0, 0,   1, 1, 4,  10, 1,  10, 0, 0, 1));
        vecs.push_back(mk(0, 0,   1, 1, 4,  10, 1,  10, 0, 0, 1));
        vecs.push_back(mk(0, 0,   1, 1, 4,  10, 1,  10, 0, 0, 1));
        vecs.push_back(mk(0, 0,   1, 0, 15, 10, 1,  0, 0, 0, 1));
        vecs.push_back(mk(1, 200, 0, 1, 1,  100, 0, 100, 0, 0, 0));
        vecs.push_back(mk(1, 3,   1, 1, 1,  100, 0, 3, 0, 0, 0));
        vecs.push_back(mk(1, 7,   0, 1, 1,  9,  0,  7, 0, 0, 0));
        vecs.push_back(mk(0, 0,   1, 1, 1,  3,  0,  3, 0, 0, 0));
        vecs.push_back(mk(0, 0,   1, 1, 0,  3,  0,  3, 0, 0, 0));
        vecs.push_back(mk(0, 0,   1, 0, 0,  3,  0,  3, 0, 0, 0));
        vecs.push_back(mk(0, 0,   1, 1, 0,  3,  1,  3, 0, 0, 0));
        vecs.push_back(mk(0, 0,   1, 0, 0,  3,  1,  3, 0, 0, 0));
        vecs.push_back(mk(1, 0,   0, 1, 5,  0,  0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0,   1, 1, 5,  0,  0,  0, 1, 0, 0));
        vecs.push_back(mk(0, 0,   1, 1, 5,  0,  0,  0, 1, 0, 0));
        vecs.push_back(mk(0, 0,   1, 0, 5,  0,  0,  0, 0, 1, 0));
        vecs.push_back(mk(0, 0,   1, 1, 15, 255, 0, 15, 0, 0, 0));
        vecs.push_back(mk(0, 0,   0, 1, 15, 255, 0, 15, 0, 0, 0));

        foreach (vecs[i]) begin
            load_en = vecs[i].ld_en; load = vecs[i].ld; en = vecs[i].en; ud = vecs[i].ud;
            step = vecs[i].step; max_val = vecs[i].mx; sat_mode = vecs[i].sat;
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].ec, vecs[i].er, vecs[i].eu, vecs[i].es);
        end

        // Randomized traffic against the reference model
        load_en = 1'b1; load = 8'd0; en = 1'b0; max_val = 8'd255;
        tick();
        m_count = 0;
        chk_all("rand_sync", 0, 0, 0, 0);
        for (int n = 0; n < 400; n++) begin
            load_en  = ($urandom_range(0, 9) == 0);
            load     = 8'($urandom_range(0, 255));
            en       = ($urandom_range(0, 4) != 0);
            ud       = 1'($urandom);
            step     = 4'($urandom_range(0, 15));
            sat_mode = 1'($urandom);
            if ($urandom_range(0, 19) == 0)
                max_val = 8'($urandom_range(0, 255));
            else if ($urandom_range(0, 7) == 0)
                max_val = 8'($urandom_range(0, 15));
            model_step();
            tick();
            chk_all($sformatf("rand%0d", n), m_count, m_r, m_u, m_s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
